// File: rtl/wb_pipe_reg.sv
// Multi-stage pipeline register with per-stage valid bit, stall hold and flush.
// Optional statistics counters are enabled with the WB_PIPE_REG_STATS_EN macro.
module wb_pipe_reg #(
    parameter int unsigned      WIDTH       = 18,
    parameter int unsigned      DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef WB_PIPE_REG_STATS_EN
    ,
    output logic [15:0]                stall_cycles,
    output logic [15:0]                bubble_cycles
`endif
);

    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_d, valid_q;
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_d[i] = RESET_VALUE;
            end
        end else if (!stall) begin
            valid_d[0] = in_valid;
            // Bubbles enter as RESET_VALUE so no stale payload travels down the pipe.
            data_d[0]  = in_valid ? in_data : RESET_VALUE;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OccW'(valid_q[i]);
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

`ifdef WB_PIPE_REG_STATS_EN
    logic [15:0] stall_cnt_d, stall_cnt_q;
    logic [15:0] bubble_cnt_d, bubble_cnt_q;

    // Both counters saturate; flush intentionally leaves them untouched.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (!valid_q[DEPTH-1] && !stall && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign bubble_cycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Scoreboard bench for wb_pipe_reg: a DEPTH=3 and a DEPTH=1 instance share the same stimulus.
// Statistics outputs are checked when WB_PIPE_REG_STATS_EN is defined.
module tb_wb_pipe_reg;

    localparam int unsigned      W   = 18;
    localparam logic [W-1:0]     RV3 = '0;
    localparam logic [W-1:0]     RV1 = 18'h15A5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, stall, flush;
    logic [W-1:0] in_data;

    logic         ov3, ov1;
    logic [W-1:0] od3, od1;
    logic [1:0]   occ3;
    logic [0:0]   occ1;
`ifdef WB_PIPE_REG_STATS_EN
    logic [15:0]  sc3, bc3, sc1, bc1;
    logic [15:0]  m_sc, m_bc3, m_bc1;
`endif

    wb_pipe_reg #(.WIDTH(W), .DEPTH(3), .RESET_VALUE(RV3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .stall     (stall),
        .flush     (flush),
        .out_valid (ov3),
        .out_data  (od3),
        .occupancy (occ3)
`ifdef WB_PIPE_REG_STATS_EN
        ,
        .stall_cycles  (sc3),
        .bubble_cycles (bc3)
`endif
    );

    wb_pipe_reg #(.WIDTH(W), .DEPTH(1), .RESET_VALUE(RV1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .stall     (stall),
        .flush     (flush),
        .out_valid (ov1),
        .out_data  (od1),
        .occupancy (occ1)
`ifdef WB_PIPE_REG_STATS_EN
        ,
        .stall_cycles  (sc1),
        .bubble_cycles (bc1)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: valid bits per stage plus in-order queues of payloads in flight.
    logic [2:0]   mv3;
    logic         mv1;
    logic [W-1:0] q3[$];
    logic [W-1:0] q1[$];
    bit           known = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("ov3", 32'(ov3), 32'(mv3[2]));
        check_eq("od3", 32'(od3), (mv3[2] && q3.size() > 0) ? 32'(q3[0]) : 32'(RV3));
        check_eq("occ3", 32'(occ3), 32'($countones(mv3)));
        check_eq("ov1", 32'(ov1), 32'(mv1));
        check_eq("od1", 32'(od1), (mv1 && q1.size() > 0) ? 32'(q1[0]) : 32'(RV1));
        check_eq("occ1", 32'(occ1), 32'(mv1));
`ifdef WB_PIPE_REG_STATS_EN
        check_eq("stall_cycles3", 32'(sc3), 32'(m_sc));
        check_eq("stall_cycles1", 32'(sc1), 32'(m_sc));
        check_eq("bubble_cycles3", 32'(bc3), 32'(m_bc3));
        check_eq("bubble_cycles1", 32'(bc1), 32'(m_bc1));
`endif
    endtask

    // Called at negedge: drive inputs, compare current outputs, step through one edge.
    task automatic cycle(input logic r, input logic iv, input logic [W-1:0] id,
                         input logic st, input logic fl, input bit chk = 1'b1);
        reset    = r;
        in_valid = iv;
        in_data  = id;
        stall    = st;
        flush    = fl;
        if (known && chk) check_outputs();
        @(posedge clk);
`ifdef WB_PIPE_REG_STATS_EN
        if (r) begin
            m_sc  = '0;
            m_bc3 = '0;
            m_bc1 = '0;
        end else begin
            if (st && !fl && m_sc != 16'hFFFF) m_sc++;
            if (!st && !mv3[2] && m_bc3 != 16'hFFFF) m_bc3++;
            if (!st && !mv1 && m_bc1 != 16'hFFFF) m_bc1++;
        end
`endif
        if (r || fl) begin
            mv3 = '0;
            mv1 = 1'b0;
            q3.delete();
            q1.delete();
        end else if (!st) begin
            if (mv3[2]) void'(q3.pop_front());
            mv3 = {mv3[1:0], iv};
            if (iv) q3.push_back(id);
            if (mv1) void'(q1.pop_front());
            mv1 = iv;
            if (iv) q1.push_back(id);
        end
        if (r) known = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        @(negedge clk);

        // Reset held for two cycles, with junk on the inputs.
        cycle(1'b1, 1'b1, 18'h3FFFF, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 18'h12345, 1'b0, 1'b0);
        check_eq("rst_ov3", 32'(ov3), 32'd0);
        check_eq("rst_od3", 32'(od3), 32'd0);
        check_eq("rst_occ3", 32'(occ3), 32'd0);

        // Latency: one valid word then bubbles; visible at DEPTH=3 after three edges only.
        cycle(1'b0, 1'b1, 18'h2A5F5, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                check_eq("lat_ov3", 32'(ov3), 32'd1);
                check_eq("lat_od3", 32'(od3), 32'h2A5F5);
            end
            cycle(1'b0, 1'b0, 18'h00000, 1'b0, 1'b0);
        end
        check_eq("lat_done_ov3", 32'(ov3), 32'd0);

        // Stall with a full pipe: outputs frozen for four cycles, then drain in order.
        cycle(1'b0, 1'b1, 18'h00001, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 18'h00002, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 18'h00003, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 18'h3ABCD, 1'b1, 1'b0);
        check_eq("stall_occ3", 32'(occ3), 32'd3);
        check_eq("stall_od3", 32'(od3), 32'h00001);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 18'h0, 1'b0, 1'b0);

        // Flush takes priority over stall.
        cycle(1'b0, 1'b1, 18'h0000A, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 18'h0000B, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 18'h0000C, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 18'h0000D, 1'b1, 1'b1);
        check_eq("flush_occ3", 32'(occ3), 32'd0);
        check_eq("flush_od3", 32'(od3), 32'(RV3));
        check_eq("flush_od1", 32'(od1), 32'(RV1));

        // Bubble with all-ones payload must come out as RESET_VALUE.
        cycle(1'b0, 1'b1, 18'h11111, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 18'h3FFFF, 1'b0, 1'b0);
        check_eq("bubble_ov1", 32'(ov1), 32'd0);
        check_eq("bubble_od1", 32'(od1), 32'(RV1));

        // Reset mid-operation discards everything, even with a valid input present.
        cycle(1'b0, 1'b1, 18'h20001, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 18'h20002, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 18'h20003, 1'b0, 1'b0);
        check_eq("midrst_occ3", 32'(occ3), 32'd0);
        cycle(1'b0, 1'b1, 18'h20004, 1'b0, 1'b0);
        check_eq("first_shift_occ3", 32'(occ3), 32'd1);

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1), W'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
        end

`ifdef WB_PIPE_REG_STATS_EN
        cycle(1'b1, 1'b0, 18'h0, 1'b0, 1'b0);
        for (int k = 0; k < 70000; k++) begin
            cycle(1'b0, 1'b0, 18'h0, 1'b1, 1'b0, (k % 1000) == 0);
        end
        check_eq("sat_stall_cycles", 32'(sc3), 32'hFFFF);
        cycle(1'b0, 1'b0, 18'h0, 1'b0, 1'b1);
        check_eq("flush_keeps_stall_cycles", 32'(sc3), 32'hFFFF);
        cycle(1'b1, 1'b0, 18'h0, 1'b0, 1'b0);
        check_eq("rst_stall_cycles", 32'(sc3), 32'd0);
        check_eq("rst_bubble_cycles", 32'(bc3), 32'd0);
`endif

        cycle(1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_pipe_reg.md
WB_PIPE_REG -- requirements
Module: wb_pipe_reg

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 18, meaning payload bits per stage.
REQ-002 The block SHALL provide parameter DEPTH, default 1, meaning number of register stages (legal range 1..8).
REQ-003 The block SHALL provide parameter RESET_VALUE, default 0 (WIDTH bits), meaning payload held by any empty stage.
REQ-004 Port clk  input  1  rising-edge clock; single clock domain.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  payload at in_data is a real instruction (0 = bubble).
REQ-007 Port in_data  input  WIDTH  control/payload word entering stage 0.
REQ-008 Port stall  input  1  hold every stage unchanged this cycle.
REQ-009 Port flush  input  1  invalidate every stage this cycle.
REQ-010 Port out_valid  output  1  valid bit of stage DEPTH-1.
REQ-011 Port out_data  output  WIDTH  payload of stage DEPTH-1.
REQ-012 Port occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-013 The block SHALL hold DEPTH stages, each a WIDTH-bit payload register plus a valid bit, all updated only on the rising edge of clk.
REQ-014 With reset=0, flush=0, stall=0: stage 0 SHALL load in_data and in_valid, and stage i SHALL load stage i-1, for i in 1..DEPTH-1.
REQ-015 When in_valid=0 on a shifting edge, stage 0 SHALL load RESET_VALUE rather than in_data (bubbles carry no stale payload).
REQ-016 Latency from in_data to out_data SHALL be exactly DEPTH cycles with no stall or flush.
REQ-017 With stall=1 and flush=0, every stage (payload and valid) SHALL retain its value; in_data SHALL be dropped.
REQ-018 With flush=1, every valid bit SHALL clear and every payload SHALL load RESET_VALUE, regardless of stall or in_valid.
REQ-019 Priority SHALL be reset > flush > stall > shift.
REQ-020 out_valid and out_data SHALL be driven directly from stage DEPTH-1 registers, with no combinational path from any input.
REQ-021 occupancy SHALL equal the number of stages whose valid bit is 1, sampled from registers; range 0..DEPTH.
REQ-022 For DEPTH=1, behaviour SHALL reduce to a single register with hold/flush, and payload reset to RESET_VALUE.

Reset
REQ-023 On a clock edge with reset=1, all valid bits SHALL clear, all payloads SHALL load RESET_VALUE, and occupancy SHALL read 0 the following cycle.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight entries on that edge; no partial shift occurs.
REQ-025 The first shift SHALL occur on the first edge with reset=0.

Configuration
REQ-026 With macro WB_PIPE_REG_STATS_EN defined, the block SHALL add outputs stall_cycles (16 bits) and bubble_cycles (16 bits).
REQ-027 stall_cycles SHALL increment on each edge with stall=1, flush=0 and reset=0, saturating at 0xFFFF.
REQ-028 bubble_cycles SHALL increment on each edge with out_valid=0, stall=0 and reset=0, saturating at 0xFFFF.
REQ-029 Both counters SHALL clear on reset only; flush SHALL NOT clear them.
REQ-030 Without WB_PIPE_REG_STATS_EN, neither port nor counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset: DEPTH=3, RESET_VALUE=18'h00000, reset=1 for 2 cycles -> out_valid=0, out_data=0, occupancy=0.
REQ-032 Latency: DEPTH=3, inject 18'h2A5F5 valid at cycle 0, then bubbles -> out_valid=1, out_data=18'h2A5F5 at cycle 3 only; occupancy steps 1,1,1,0.
REQ-033 Stall: DEPTH=2, values 18'h00001, 18'h00002 in flight; stall=1 for 4 cycles -> outputs frozen, occupancy=2; after release 18'h00001 then 18'h00002 emerge.
REQ-034 Flush over stall: stall=1, flush=1 with occupancy=3 -> next cycle occupancy=0, out_data=RESET_VALUE, out_valid=0.
REQ-035 Bubble payload: in_valid=0, in_data=18'h3FFFF, DEPTH=1 -> out_data=RESET_VALUE, out_valid=0.
REQ-036 Stats (macro defined): 70000 cycles stall=1 -> stall_cycles=0xFFFF (saturated); flush does not clear it; reset clears to 0.
